// File: rtl/radio_pkg.sv
// Shared constants and types for the synthetic MAX2769 radio source.
package radio_pkg;

   localparam int LFSR_W = 16;
   // Right-shift Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
   localparam logic [LFSR_W-1:0] LFSR_TAPS   = 16'h002D;
   localparam logic [LFSR_W-1:0] LFSR_SEED_I = 16'hACE1;
   localparam logic [LFSR_W-1:0] LFSR_SEED_Q = 16'h1D2B;

   typedef logic [4:0] ant_idx_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } emu_state_t;

endpackage

// File: rtl/radio_lfsr.sv
// 16-bit Fibonacci noise LFSR; noise is bit 0 of the current state, step advances it once.
module radio_lfsr
   import radio_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_I
) (
   input  logic clk16,
   input  logic rst,
   input  logic step,
   output logic noise
);

   logic [LFSR_W-1:0] state;

   assign noise = state[0];

   always_ff @(posedge clk16) begin
      if (rst) begin
         state <= SEED;
      end else if (step) begin
         state <= {^(state & LFSR_TAPS), state[LFSR_W-1:1]};
      end
   end

endmodule

// File: rtl/radio_emulator.sv
// Synthetic multi-antenna 1-bit I/Q source: shared LFSR noise through a history line,
// tapped per antenna at a programmable lag, free-running or in bursts.
module radio_emulator
   import radio_pkg::*;
#(
   parameter int NUM_ANT    = 24,
   parameter int MAX_DELAY  = 15,
   parameter int DELAY_W    = 4,
   parameter int SAMPLE_DIV = 1
) (
   input  logic               clk16,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [31:0]        burst_len,
   input  logic               wr_en,
   input  ant_idx_t           wr_addr,
   input  logic [DELAY_W-1:0] wr_delay,
   output logic [NUM_ANT-1:0] out_radio_i,
   output logic [NUM_ANT-1:0] out_radio_q,
   output logic               running,
   output logic               done,
   output logic [31:0]        sample_count
);

   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

   emu_state_t         state;
   logic [DIV_W-1:0]   div;
   logic [MAX_DELAY:0] hist_i, hist_q;
   logic [MAX_DELAY:0] hist_i_next, hist_q_next;
   logic [DELAY_W-1:0] delay [NUM_ANT];
   logic               noise_i, noise_q;
   logic               strobe, last;

   // stop takes priority over the sample that would otherwise be emitted this cycle.
   assign strobe      = (state == RUN) && !stop && (div == '0);
   assign last        = strobe && (burst_len != '0) && (sample_count + 32'd1 == burst_len);
   assign hist_i_next = {hist_i[MAX_DELAY-1:0], noise_i};
   assign hist_q_next = {hist_q[MAX_DELAY-1:0], noise_q};
   assign running     = (state == RUN);

   radio_lfsr #(.SEED(LFSR_SEED_I)) u_lfsr_i (
      .clk16 (clk16),
      .rst   (rst),
      .step  (strobe),
      .noise (noise_i)
   );

   radio_lfsr #(.SEED(LFSR_SEED_Q)) u_lfsr_q (
      .clk16 (clk16),
      .rst   (rst),
      .step  (strobe),
      .noise (noise_q)
   );

   always_ff @(posedge clk16) begin
      if (rst) begin
         delay <= '{default: '0};
      end else if (wr_en && (32'(wr_addr) < NUM_ANT)) begin
         delay[wr_addr] <= (32'(wr_delay) > MAX_DELAY) ? DELAY_W'(MAX_DELAY) : wr_delay;
      end
   end

   always_ff @(posedge clk16) begin
      if (rst) begin
         state        <= IDLE;
         div          <= '0;
         hist_i       <= '0;
         hist_q       <= '0;
         out_radio_i  <= '0;
         out_radio_q  <= '0;
         done         <= 1'b0;
         sample_count <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               out_radio_i <= '0;
               out_radio_q <= '0;
               if (start && !stop) begin
                  state        <= RUN;
                  sample_count <= '0;
                  hist_i       <= '0;
                  hist_q       <= '0;
                  div          <= '0;
               end
            end
            RUN: begin
               if (stop) begin
                  state       <= IDLE;
                  done        <= 1'b1;
                  out_radio_i <= '0;
                  out_radio_q <= '0;
               end else begin
                  div <= (div == DIV_LAST) ? '0 : div + 1'b1;
                  if (strobe) begin
                     hist_i       <= hist_i_next;
                     hist_q       <= hist_q_next;
                     sample_count <= sample_count + 32'd1;
                     // Taps read the post-shift line so lag 0 is the sample just generated.
                     for (int a = 0; a < NUM_ANT; a++) begin
                        out_radio_i[a] <= hist_i_next[delay[a]];
                        out_radio_q[a] <= hist_q_next[delay[a]];
                     end
                     if (last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_radio_emulator.sv
// Bench for radio_emulator: two instances (sample divider 1 and 3) share one stimulus stream
// and are checked every cycle against a sample-sequence reference model.
module tb_radio_emulator;

   localparam int NUM_ANT   = 24;
   localparam int MAX_DELAY = 15;
   localparam int DELAY_W   = 5;
   localparam int VW        = 2 + 32 + 2 * NUM_ANT;
   localparam int SMAX      = 1024;

   // ---------------- clock / reset ----------------
   logic clk16 = 1'b0;
   always #5 clk16 = ~clk16;

   logic               rst, start, stop, wr_en;
   logic [31:0]        burst_len;
   logic [4:0]         wr_addr;
   logic [DELAY_W-1:0] wr_delay;

   logic [NUM_ANT-1:0] oi_a, oq_a, oi_b, oq_b;
   logic               run_a, run_b, done_a, done_b;
   logic [31:0]        cnt_a, cnt_b;

   radio_emulator #(.NUM_ANT(NUM_ANT), .MAX_DELAY(MAX_DELAY), .DELAY_W(DELAY_W), .SAMPLE_DIV(1)) dut_a (
      .clk16(clk16), .rst(rst), .start(start), .stop(stop), .burst_len(burst_len),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_delay(wr_delay),
      .out_radio_i(oi_a), .out_radio_q(oq_a), .running(run_a), .done(done_a), .sample_count(cnt_a)
   );

   radio_emulator #(.NUM_ANT(NUM_ANT), .MAX_DELAY(MAX_DELAY), .DELAY_W(DELAY_W), .SAMPLE_DIV(3)) dut_b (
      .clk16(clk16), .rst(rst), .start(start), .stop(stop), .burst_len(burst_len),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_delay(wr_delay),
      .out_radio_i(oi_b), .out_radio_q(oq_b), .running(run_b), .done(done_b), .sample_count(cnt_b)
   );

   // ---------------- scoreboard ----------------
   int vectors = 0;
   int errors  = 0;
   int done_seen_a = 0;
   int done_seen_b = 0;
   logic [VW-1:0] exp_q_a[$];
   logic [VW-1:0] exp_q_b[$];

   task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %h want %h", name, $time, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Each run is a numbered sequence of noise samples; antenna output with lag d at sample n
   // is sample n-d of the current run, or 0 before the run has produced that many samples.
   bit               model_on = 1'b0;
   bit               m_run  [2];
   bit               m_done [2];
   int               m_cyc  [2];
   logic [31:0]      m_cnt  [2];
   logic [15:0]      m_li   [2];
   logic [15:0]      m_lq   [2];
   logic [NUM_ANT-1:0] m_oi [2];
   logic [NUM_ANT-1:0] m_oq [2];
   bit               m_si   [2][SMAX];
   bit               m_sq   [2][SMAX];
   int               m_delay[NUM_ANT];
   int               div_of [2] = '{1, 3};

   // x^16+x^14+x^13+x^11+1, shifting right, new bit enters at the top.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   always @(posedge clk16) begin
      int n, d;
      if (model_on) begin
         for (int k = 0; k < 2; k++) begin
            if (rst) begin
               m_run[k] = 0; m_done[k] = 0; m_cnt[k] = '0; m_cyc[k] = 0;
               m_oi[k] = '0; m_oq[k] = '0;
               m_li[k] = 16'hACE1; m_lq[k] = 16'h1D2B;
            end else begin
               m_done[k] = 0;
               if (!m_run[k]) begin
                  m_oi[k] = '0; m_oq[k] = '0;
                  if (start && !stop) begin
                     m_run[k] = 1; m_cnt[k] = '0; m_cyc[k] = 0;
                  end
               end else if (stop) begin
                  m_run[k] = 0; m_done[k] = 1; m_oi[k] = '0; m_oq[k] = '0;
               end else begin
                  if (m_cyc[k] % div_of[k] == 0) begin
                     n = int'(m_cnt[k]) + 1;
                     m_si[k][n % SMAX] = m_li[k][0];
                     m_sq[k][n % SMAX] = m_lq[k][0];
                     m_li[k] = lfsr_next(m_li[k]);
                     m_lq[k] = lfsr_next(m_lq[k]);
                     m_cnt[k] = m_cnt[k] + 32'd1;
                     for (int a = 0; a < NUM_ANT; a++) begin
                        d = m_delay[a];
                        m_oi[k][a] = (n > d) ? m_si[k][(n - d) % SMAX] : 1'b0;
                        m_oq[k][a] = (n > d) ? m_sq[k][(n - d) % SMAX] : 1'b0;
                     end
                     if (burst_len != 0 && m_cnt[k] == burst_len) begin
                        m_run[k] = 0; m_done[k] = 1;
                     end
                  end
                  m_cyc[k]++;
               end
            end
         end
         if (rst) begin
            foreach (m_delay[a]) m_delay[a] = 0;
         end else if (wr_en && int'(wr_addr) < NUM_ANT) begin
            m_delay[wr_addr] = (int'(wr_delay) > MAX_DELAY) ? MAX_DELAY : int'(wr_delay);
         end
         exp_q_a.push_back({m_run[0], m_done[0], m_cnt[0], m_oq[0], m_oi[0]});
         exp_q_b.push_back({m_run[1], m_done[1], m_cnt[1], m_oq[1], m_oi[1]});
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk16) begin
      if (exp_q_a.size() > 0) check("div1_outputs", {run_a, done_a, cnt_a, oq_a, oi_a}, exp_q_a.pop_front());
      if (exp_q_b.size() > 0) check("div3_outputs", {run_b, done_b, cnt_b, oq_b, oi_b}, exp_q_b.pop_front());
      if (done_a === 1'b1) done_seen_a++;
      if (done_b === 1'b1) done_seen_b++;
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk16);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   task automatic write_delay(input int a, input int d);
      wr_en = 1'b1; wr_addr = 5'(a); wr_delay = DELAY_W'(d);
      tick();
      wr_en = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int da, db, len;
      rst = 1'b1; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
      wr_addr = '0; wr_delay = '0; burst_len = '0;
      model_on = 1'b1;
      tick(2);
      rst = 1'b0;

      // Reset state then first samples of a free run.
      pulse_start();
      tick(8);
      pulse_stop();
      tick(3);

      // All lags zero, 100 free-run samples on the divide-by-1 instance.
      pulse_start();
      tick(100);
      check("count_after_100", VW'(cnt_a), VW'(32'd100));
      pulse_stop();
      tick(2);

      // Lag 2 on antenna 3, an over-range lag on antenna 7.
      write_delay(3, 2);
      write_delay(7, 20);
      pulse_start();
      tick(60);
      pulse_stop();
      tick(2);

      // Ten-sample burst.
      burst_len = 32'd10;
      da = done_seen_a; db = done_seen_b;
      pulse_start();
      tick(40);
      check("burst_count_div3", VW'(cnt_b), VW'(32'd10));
      check("burst_running_div3", VW'(run_b), VW'(1'b0));
      check("burst_done_pulses_div1", VW'(done_seen_a - da), VW'(1));
      check("burst_done_pulses_div3", VW'(done_seen_b - db), VW'(1));
      burst_len = '0;

      // Stop and start together while running, then a restart five cycles later.
      pulse_start();
      tick(20);
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      tick(4);
      pulse_start();
      tick(10);
      pulse_stop();
      tick(2);

      // Reset in the middle of a burst.
      write_delay(5, 9);
      burst_len = 32'd10;
      pulse_start();
      tick(6);
      rst = 1'b1; tick(); rst = 1'b0;
      burst_len = '0;
      pulse_start();
      tick(20);
      pulse_stop();
      tick(2);

      // Randomised runs with stray controls and delay writes.
      for (int it = 0; it < 40; it++) begin
         repeat ($urandom_range(0, 3)) write_delay($urandom_range(0, 31), $urandom_range(0, 31));
         burst_len = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 25)) : 32'd0;
         pulse_start();
         len = $urandom_range(5, 80);
         for (int c = 0; c < len; c++) begin
            start    = ($urandom_range(0, 15) == 0);
            stop     = ($urandom_range(0, 31) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            wr_en    = ($urandom_range(0, 7) == 0);
            wr_addr  = 5'($urandom_range(0, 31));
            wr_delay = DELAY_W'($urandom_range(0, 31));
            tick();
         end
         start = 1'b0; rst = 1'b0; wr_en = 1'b0;
         pulse_stop();
         tick(2);
      end

      model_on = 1'b0;
      tick(2);
      check("queue_drain", VW'(exp_q_a.size() + exp_q_b.size()), VW'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
